// File: rtl/c0_exc_ctrl.sv
// rtl/c0_exc_ctrl.sv - CP0 exception/interrupt request generator and ERET sequencer
module c0_exc_ctrl #(
   parameter int          IRQ_W       = 6,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] VECTOR      = 32'h8000_0180
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IRQ_W-1:0] irq,
   input  logic             commit_valid,
   input  logic [31:0]      commit_pc,
   input  logic             commit_bd,
   input  logic             exc_ov,
   input  logic             exc_sys,
   input  logic             exc_bp,
   input  logic             eret,
   input  logic [31:0]      Status,
   input  logic [31:0]      EPC,
   output logic             INT,
   output logic [31:0]      wepc,
   output logic [31:0]      wcause,
   output logic [31:0]      wstatus,
   output logic             c0w,
   output logic [4:0]       waddr,
   output logic [31:0]      wdata,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic             double_fault
);

   typedef enum logic [1:0] {S_IDLE, S_TAKE, S_HANDLER, S_RETURN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IRQ_W-1:0]  r_sync [SYNC_STAGES];
   logic [IRQ_W-1:0]  w_ip;
   logic              w_sync_exc;
   logic              w_int_ok;
   logic              w_take;
   logic              w_ret;
   logic              w_dfault;
   logic [4:0]        w_exccode;
   logic [31:0]       w_cause;
   logic [31:0]       r_wepc;
   logic [31:0]       r_wcause;
   logic [31:0]       r_wstatus;
   logic [31:0]       r_wdata;
   logic [31:0]       r_redirect_pc;
   logic              r_dfault;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= irq;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_ip       = r_sync[SYNC_STAGES-1];
   assign w_sync_exc = exc_ov | exc_sys | exc_bp;
   assign w_int_ok   = Status[0] & ~Status[1] & (|(w_ip & Status[10 +: IRQ_W])) & (r_state == S_IDLE);
   // ERET outranks interrupts, so an ERET commit in IDLE swallows a pending IRQ for that cycle.
   assign w_take     = (r_state == S_IDLE) & commit_valid & (w_sync_exc | (~eret & w_int_ok));
   assign w_ret      = (r_state == S_HANDLER) & commit_valid & eret & ~w_sync_exc;
   assign w_dfault   = (r_state == S_HANDLER) & commit_valid & w_sync_exc;

   always_comb begin
      w_exccode = 5'd0;
      if (exc_ov)       w_exccode = 5'd12;
      else if (exc_sys) w_exccode = 5'd8;
      else if (exc_bp)  w_exccode = 5'd9;
      w_cause             = '0;
      w_cause[31]         = commit_bd;
      w_cause[10 +: IRQ_W] = w_ip;
      w_cause[6:2]        = w_exccode;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_take) w_next = S_TAKE;
         S_TAKE:    w_next = S_HANDLER;
         S_HANDLER: if (w_ret) w_next = S_RETURN;
         S_RETURN:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wepc        <= '0;
         r_wcause      <= '0;
         r_wstatus     <= '0;
         r_wdata       <= '0;
         r_redirect_pc <= '0;
         r_dfault      <= 1'b0;
      end else begin
         if (w_take) begin
            r_wepc        <= commit_bd ? commit_pc - 32'd4 : commit_pc;
            r_wcause      <= w_cause;
            r_wstatus     <= {Status[31:2], 1'b1, Status[0]};
            r_redirect_pc <= VECTOR;
         end
         if (w_ret) begin
            r_wdata       <= {Status[31:2], 1'b0, Status[0]};
            r_redirect_pc <= EPC;
         end
         if (w_dfault) r_dfault <= 1'b1;
      end
   end

   always_comb begin
      INT          = (r_state == S_TAKE);
      c0w          = (r_state == S_RETURN);
      redirect     = (r_state == S_TAKE) | (r_state == S_RETURN);
      flush        = redirect;
      waddr        = c0w ? 5'd12 : 5'd0;
      wepc         = r_wepc;
      wcause       = r_wcause;
      wstatus      = r_wstatus;
      wdata        = r_wdata;
      redirect_pc  = r_redirect_pc;
      double_fault = r_dfault;
   end

endmodule

// File: tb/tb_c0_exc_ctrl.sv
// tb/tb_c0_exc_ctrl.sv - directed self-checking bench for c0_exc_ctrl
module tb_c0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  irq;
   logic        commit_valid, commit_bd, exc_ov, exc_sys, exc_bp, eret;
   logic [31:0] commit_pc, Status, EPC;
   logic        INT, c0w, redirect, flush, double_fault;
   logic [31:0] wepc, wcause, wstatus, wdata, redirect_pc;
   logic [4:0]  waddr;

   int n_cmp = 0;
   int n_err = 0;

   c0_exc_ctrl #(.IRQ_W(6), .SYNC_STAGES(2), .VECTOR(32'h8000_0180)) dut (
      .clk(clk), .rst(rst), .irq(irq), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_bd(commit_bd), .exc_ov(exc_ov), .exc_sys(exc_sys), .exc_bp(exc_bp), .eret(eret),
      .Status(Status), .EPC(EPC), .INT(INT), .wepc(wepc), .wcause(wcause), .wstatus(wstatus),
      .c0w(c0w), .waddr(waddr), .wdata(wdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush), .double_fault(double_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_commit();
      commit_valid = 0; commit_bd = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0; eret = 0;
   endtask

   initial begin
      rst = 1; irq = '0; commit_pc = '0; Status = '0; EPC = '0;
      clear_commit();
      tick(); tick();
      chk("rst_int", {31'd0, INT}, 32'd0);
      chk("rst_c0w", {31'd0, c0w}, 32'd0);
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_dfault", {31'd0, double_fault}, 32'd0);
      chk("rst_wepc", wepc, 32'd0);
      chk("rst_wcause", wcause, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      rst = 0;

      // interrupt latency: irq rise -> INT three cycles later
      Status = 32'h0000_0401; commit_valid = 1; commit_pc = 32'h0000_0100;
      tick(); chk("t1_no_irq", {31'd0, INT}, 32'd0);
      irq = 6'b000001;
      tick(); chk("t1_c1", {31'd0, INT}, 32'd0);
      tick(); chk("t1_c2", {31'd0, INT}, 32'd0);
      tick();
      chk("t1_int", {31'd0, INT}, 32'd1);
      chk("t1_wepc", wepc, 32'h0000_0100);
      chk("t1_wcause", wcause, 32'h0000_0400);
      chk("t1_wstatus", wstatus, 32'h0000_0403);
      chk("t1_redirect", {31'd0, redirect}, 32'd1);
      chk("t1_flush", {31'd0, flush}, 32'd1);
      chk("t1_redirect_pc", redirect_pc, 32'h8000_0180);
      chk("t1_c0w", {31'd0, c0w}, 32'd0);
      commit_valid = 0;
      tick();
      chk("t1_int_drop", {31'd0, INT}, 32'd0);
      chk("t1_redirect_drop", {31'd0, redirect}, 32'd0);

      // handler ignores interrupts even with IE=1, EXL=0
      Status = 32'h0000_0401; commit_valid = 1; commit_pc = 32'h0000_0108;
      tick(); chk("t4_hdl_int_a", {31'd0, INT}, 32'd0);
      tick(); chk("t4_hdl_int_b", {31'd0, INT}, 32'd0);

      // ERET return sequence
      Status = 32'h0000_0403; EPC = 32'h0000_0100; eret = 1;
      tick();
      chk("t3_c0w", {31'd0, c0w}, 32'd1);
      chk("t3_waddr", {27'd0, waddr}, 32'd12);
      chk("t3_wdata", wdata, 32'h0000_0401);
      chk("t3_redirect", {31'd0, redirect}, 32'd1);
      chk("t3_flush", {31'd0, flush}, 32'd1);
      chk("t3_redirect_pc", redirect_pc, 32'h0000_0100);
      chk("t3_int", {31'd0, INT}, 32'd0);
      clear_commit(); Status = 32'h0000_0401;
      tick();
      chk("t3_c0w_drop", {31'd0, c0w}, 32'd0);
      chk("t3_idle_int", {31'd0, INT}, 32'd0);
      chk("t3_redirect_drop", {31'd0, redirect}, 32'd0);

      // irq still held: first commit after return takes it
      commit_valid = 1; commit_pc = 32'h0000_0104;
      tick();
      chk("t4_int", {31'd0, INT}, 32'd1);
      chk("t4_wepc", wepc, 32'h0000_0104);
      chk("t4_wcause", wcause, 32'h0000_0400);
      clear_commit(); irq = '0;
      tick();
      Status = 32'h0000_0403; EPC = 32'h0000_0104; commit_valid = 1; eret = 1;
      tick();
      chk("t4_ret_c0w", {31'd0, c0w}, 32'd1);
      chk("t4_ret_pc", redirect_pc, 32'h0000_0104);
      clear_commit(); Status = 32'h0000_0401;
      tick();

      // overflow beats syscall, branch-delay EPC adjust
      commit_valid = 1; exc_ov = 1; exc_sys = 1; commit_bd = 1; commit_pc = 32'h0000_0200;
      tick();
      chk("t2_int", {31'd0, INT}, 32'd1);
      chk("t2_wepc", wepc, 32'h0000_01FC);
      chk("t2_wcause", wcause, 32'h8000_0030);
      chk("t2_wstatus", wstatus, 32'h0000_0403);
      chk("t2_redirect_pc", redirect_pc, 32'h8000_0180);
      clear_commit();
      tick();
      chk("t2_int_drop", {31'd0, INT}, 32'd0);

      // exception plus eret inside handler -> double fault, no return
      commit_valid = 1; exc_sys = 1; eret = 1;
      tick();
      chk("t5_dfault", {31'd0, double_fault}, 32'd1);
      chk("t5_int", {31'd0, INT}, 32'd0);
      chk("t5_c0w", {31'd0, c0w}, 32'd0);
      chk("t5_redirect", {31'd0, redirect}, 32'd0);
      clear_commit();
      tick(); tick();
      chk("t5_dfault_sticky", {31'd0, double_fault}, 32'd1);
      chk("t5_c0w_late", {31'd0, c0w}, 32'd0);
      rst = 1;
      tick();
      chk("t5_dfault_rst", {31'd0, double_fault}, 32'd0);
      rst = 0;

      // masked interrupts
      Status = 32'h0000_0400; irq = 6'b000001; commit_valid = 1; commit_pc = 32'h0000_0300;
      for (int i = 0; i < 4; i++) begin
         tick(); chk($sformatf("t6_ie0_%0d", i), {31'd0, INT}, 32'd0);
      end
      Status = 32'h0000_0801;
      for (int i = 0; i < 2; i++) begin
         tick(); chk($sformatf("t6_im_%0d", i), {31'd0, INT}, 32'd0);
      end
      Status = 32'h0000_0401;
      tick();
      chk("t6_int", {31'd0, INT}, 32'd1);
      #1 rst = 1;
      #1;
      chk("t6_rst_int", {31'd0, INT}, 32'd0);
      chk("t6_rst_redirect", {31'd0, redirect}, 32'd0);
      chk("t6_rst_flush", {31'd0, flush}, 32'd0);
      tick();
      rst = 0;
      tick(); chk("t6_post_c1", {31'd0, INT}, 32'd0);
      tick(); chk("t6_post_c2", {31'd0, INT}, 32'd0);
      tick(); chk("t6_post_int", {31'd0, INT}, 32'd1);

      // branch-delay EPC wrap at PC 0
      rst = 1; irq = '0; clear_commit();
      tick();
      rst = 0; Status = 32'h0000_0000;
      commit_valid = 1; commit_bd = 1; commit_pc = 32'h0000_0000; exc_bp = 1;
      tick();
      chk("wrap_int", {31'd0, INT}, 32'd1);
      chk("wrap_wepc", wepc, 32'hFFFF_FFFC);
      chk("wrap_wcause", wcause, 32'h8000_0024);
      chk("wrap_wstatus", wstatus, 32'h0000_0002);
      clear_commit();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/c0_exc_ctrl.md
Name: c0_exc_ctrl

Overview:
- Exception/interrupt request generator that drives the CP0 register file's capture port (INT, wepc, wcause, wstatus).
- Synchronises external IRQ lines, arbitrates them against synchronous exceptions at the instruction-commit boundary, and pulses INT.
- Tracks handler residency and sequences ERET: restores Status through the CP0 write port and redirects fetch to EPC.
- Sits between the pipeline commit stage and the CP0 register file.

Parameters:
IRQ_W, 6, number of external hardware interrupt lines (map to Cause/Status bits 15:10)
SYNC_STAGES, 2, flip-flop stages on each IRQ line (minimum 2)
VECTOR, 32'h8000_0180, exception handler entry PC

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
irq  in  IRQ_W  asynchronous level interrupt lines
commit_valid  in  1  instruction at commit boundary this cycle; only point where exceptions are taken
commit_pc  in  32  PC of committing instruction
commit_bd  in  1  committing instruction is in a branch delay slot
exc_ov  in  1  committing instruction overflowed (ExcCode 12)
exc_sys  in  1  committing instruction is SYSCALL (ExcCode 8)
exc_bp  in  1  committing instruction is BREAK (ExcCode 9)
eret  in  1  committing instruction is ERET (qualified by commit_valid)
Status  in  32  current CP0 Status (bit0 IE, bit1 EXL, bits 15:10 IM)
EPC  in  32  current CP0 EPC
INT  out  1  one-cycle capture strobe to CP0
wepc  out  32  EPC value to capture
wcause  out  32  Cause value to capture
wstatus  out  32  Status value to capture
c0w  out  1  one-cycle CP0 write strobe (ERET Status restore)
waddr  out  5  CP0 write address (always 12 when c0w)
wdata  out  32  CP0 write data
redirect  out  1  one-cycle fetch redirect
redirect_pc  out  32  redirect target
flush  out  1  one-cycle pipeline flush (same cycle as redirect)
double_fault  out  1  sticky: synchronous exception while in handler

Behaviour:
- Reset (async): all outputs 0, sync chains 0, pending 0, state IDLE; double_fault cleared only by rst.
- IRQ path: each line passes SYNC_STAGES flops; ip[IRQ_W-1:0] = synchronised level (no latching; source holds until serviced).
- int_ok = Status[0] & ~Status[1] & |(ip & Status[15:10]) & state==IDLE.
- States: IDLE, TAKE, HANDLER, RETURN.
- IDLE, commit_valid=1, priority exc_ov > exc_sys > exc_bp > eret > interrupt:
  - sync exception or int_ok -> TAKE. Registered outputs valid in TAKE cycle: INT=1; wepc = commit_bd ? commit_pc-4 : commit_pc; wcause[31]=commit_bd, wcause[15:10]=ip, wcause[6:2]=ExcCode (0 for interrupt), other bits 0; wstatus = {Status[31:2],1'b1,Status[0]}; redirect=1, redirect_pc=VECTOR, flush=1.
  - eret (no exception) -> IDLE with no action; ERET outside handler is a no-op.
- TAKE -> HANDLER unconditionally after one cycle; INT/redirect/flush deassert.
- HANDLER: interrupts ignored regardless of Status.
  - commit_valid & eret & no sync exception -> RETURN.
  - Sync exception -> set double_fault; no INT; stay HANDLER.
  - Sync exception plus eret in the same cycle: exception wins (double_fault), no return.
- RETURN (one cycle): c0w=1, waddr=12, wdata={Status[31:2],1'b0,Status[0]}; redirect=1, redirect_pc=EPC, flush=1 -> IDLE.
- First commit after RETURN is eligible for interrupt; a pending unmasked IRQ is taken on the next commit_valid cycle.
- Latency: exception commit cycle N -> INT/redirect at N+1; ERET commit at N -> c0w/redirect at N+1. IRQ edge -> earliest INT at SYNC_STAGES+1 cycles, given a commit.
- commit_bd with commit_pc=0: wepc wraps to 32'hFFFF_FFFC (mod 2^32).
- INT and c0w are never asserted in the same cycle.
- Reset mid-TAKE/RETURN aborts the strobes immediately (async).

Test Plan:
1. Status=32'h0000_0401, irq=6'b000001 held, commit_valid=1 each cycle, commit_pc=32'h0000_0100 -> INT one cycle, 3 cycles after irq rise; wepc=32'h100, wcause=32'h0000_0400, wstatus=32'h0000_0403, redirect_pc=32'h8000_0180.
2. commit_valid=1, exc_ov=1, exc_sys=1, commit_bd=1, commit_pc=32'h200 -> wepc=32'h1FC, wcause=32'h8000_0030 (ExcCode 12 | BD); exc_sys ignored.
3. In HANDLER, Status=32'h0000_0403, EPC=32'h0000_0100; eret commit -> next cycle c0w=1, waddr=12, wdata=32'h0000_0401, redirect_pc=32'h100; state IDLE.
4. irq held asserted through handler and return -> no INT in HANDLER; INT on the first commit after RETURN.
5. In HANDLER, exc_sys=1 with eret=1 -> double_fault=1 sticky, no INT, no c0w, stays HANDLER until rst.
6. Status IE=0 or IM bit clear with irq active -> no INT; assert rst during TAKE -> INT and redirect drop to 0 in the same cycle, state IDLE.
